// File: rtl/mem_cfg_arbiter_if.sv
// Memory-config bus bundle: requester side (req_*/rsp_*) and the
// single shared memory-config port (mem_*). The arbiter uses the slave view,
// the environment (requesters plus memory) uses the master view.
interface mem_cfg_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*8-1:0] req_addr;
  logic [N_REQ*8-1:0] req_wdata;
  logic [N_REQ-1:0]   req_wr_rd_s;
  logic [N_REQ-1:0]   req_grant;
  logic [N_REQ-1:0]   req_done;
  logic [31:0]        rsp_rdata;
  logic [3:0]         rsp_ack;
  logic               rsp_err;
  logic               busy;
  logic               mem_sel_en;
  logic [7:0]         mem_addr;
  logic [7:0]         mem_wr_data;
  logic               mem_wr_rd_s;
  logic [31:0]        mem_rd_data;
  logic [3:0]         mem_ack;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wr_rd_s, mem_rd_data, mem_ack,
    output req_grant, req_done, rsp_rdata, rsp_ack, rsp_err, busy,
           mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wr_rd_s, mem_rd_data, mem_ack,
    input  req_grant, req_done, rsp_rdata, rsp_ack, rsp_err, busy,
           mem_sel_en, mem_addr, mem_wr_data, mem_wr_rd_s
  );
endinterface

// File: rtl/mem_cfg_arbiter.sv
// Round-robin arbiter sharing one memory-config bus between N_REQ requesters.
// One transaction at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// WAIT ends on any mem_ack bit or after TIMEOUT_CYC cycles (error completion).
module mem_cfg_arbiter #(
  parameter int N_REQ       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  mem_cfg_arbiter_if.slave  bus
);
  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_reg;
  logic [IDXW-1:0]  rr_reg;
  logic [TW-1:0]    timer_reg;
  logic [N_REQ-1:0] grant_reg;
  logic [N_REQ-1:0] done_reg;
  logic [31:0]      rdata_reg;
  logic [3:0]       ack_reg;
  logic             err_reg;
  logic             busy_reg;
  logic             sel_en_reg;
  logic [7:0]       addr_reg;
  logic [7:0]       wdata_reg;
  logic             wr_reg;

  // Unpacked per-requester views of the packed address/data buses
  logic [7:0] addr_arr [N_REQ];
  logic [7:0] wdata_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[8*gi +: 8];
      assign wdata_arr[gi] = bus.req_wdata[8*gi +: 8];
    end
  endgenerate

  logic            pick_found;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] rr_next;
  int              cand;

  // First valid requester at or after the round-robin pointer, wrapping
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(rr_reg) + k) % N_REQ;
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDXW'(cand);
      end
    end
    rr_next = (int'(pick_idx) == N_REQ - 1) ? '0 : pick_idx + 1'b1;
  end

  // Transaction FSM; every output is a register updated here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_reg     <= '0;
      timer_reg  <= '0;
      grant_reg  <= '0;
      done_reg   <= '0;
      rdata_reg  <= '0;
      ack_reg    <= '0;
      err_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      sel_en_reg <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wr_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            // Request fields are latched here; later changes are ignored
            addr_reg            <= addr_arr[pick_idx];
            wdata_reg           <= wdata_arr[pick_idx];
            wr_reg              <= bus.req_wr_rd_s[pick_idx];
            grant_reg           <= '0;
            grant_reg[pick_idx] <= 1'b1;
            rr_reg              <= rr_next;
            sel_en_reg          <= 1'b1;
            busy_reg            <= 1'b1;
            state_reg           <= ISSUE;
          end
        end
        ISSUE: begin
          // mem_ack is deliberately not looked at while the strobe is out
          sel_en_reg <= 1'b0;
          timer_reg  <= '0;
          state_reg  <= WAIT;
        end
        WAIT: begin
          if (|bus.mem_ack) begin
            ack_reg   <= bus.mem_ack;
            rdata_reg <= wr_reg ? 32'h0 : bus.mem_rd_data;
            err_reg   <= 1'b0;
            done_reg  <= grant_reg;
            state_reg <= RESP;
          end else if (timer_reg == TW'(TIMEOUT_CYC - 1)) begin
            ack_reg   <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b1;
            done_reg  <= grant_reg;
            state_reg <= RESP;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        RESP: begin
          done_reg  <= '0;
          grant_reg <= '0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.req_grant   = grant_reg;
  assign bus.req_done    = done_reg;
  assign bus.rsp_rdata   = rdata_reg;
  assign bus.rsp_ack     = ack_reg;
  assign bus.rsp_err     = err_reg;
  assign bus.busy        = busy_reg;
  assign bus.mem_sel_en  = sel_en_reg;
  assign bus.mem_addr    = addr_reg;
  assign bus.mem_wr_data = wdata_reg;
  assign bus.mem_wr_rd_s = wr_reg;
endmodule

// File: tb/tb_mem_cfg_arbiter.sv
// Bench for mem_cfg_arbiter: scenario tasks plus randomized traffic, checked
// against a transaction-level model (round-robin pick by scanning a mask,
// completion time and response computed from the chosen ack delay).
module tb_mem_cfg_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int OW = 2*N + 56;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_cfg_arbiter_if #(.N_REQ(N)) bus();

  mem_cfg_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  int model_rr = 0;
  logic [31:0] prev_rdata = '0;
  logic [3:0]  prev_ack   = '0;
  logic        prev_err   = 1'b0;

  function automatic logic [OW-1:0] all_outs();
    return {bus.req_grant, bus.req_done, bus.rsp_rdata, bus.rsp_ack, bus.rsp_err,
            bus.busy, bus.mem_sel_en, bus.mem_addr, bus.mem_wr_data, bus.mem_wr_rd_s};
  endfunction

  function automatic int model_pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(model_rr + k) % N]) return (model_rr + k) % N;
    return 0;
  endfunction

  task automatic scramble_reqs();
    for (int i = 0; i < N; i++) begin
      bus.req_addr[8*i +: 8]  = 8'($urandom);
      bus.req_wdata[8*i +: 8] = 8'($urandom);
      bus.req_wr_rd_s[i]      = 1'($urandom);
    end
  endtask

  // One full transaction: arbitration, issue, wait with ack at WAIT cycle
  // 'delay' (negative or >= TO means never), completion and the idle gap.
  task automatic run_txn(input logic [N-1:0] mask, input int delay, input logic [3:0] ackv,
                         input logic [31:0] rd, input bit drop_mid, input bit issue_noise,
                         output int obs_w);
    int w;
    bit seen;
    int done_at;
    logic [7:0] ea, ed;
    logic ew, exp_err;
    logic [31:0] exp_rd;
    logic [3:0] exp_ack;
    logic [N-1:0] oh;
    bus.req_valid = mask;
    w = model_pick(mask);
    model_rr = (w + 1) % N;
    oh = '0;
    oh[w] = 1'b1;
    ea = bus.req_addr[8*w +: 8];
    ed = bus.req_wdata[8*w +: 8];
    ew = bus.req_wr_rd_s[w];
    exp_err = (delay < 0) || (delay >= TO);
    exp_ack = exp_err ? 4'h0 : ackv;
    exp_rd  = (exp_err || ew) ? 32'h0 : rd;
    obs_w = -1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_sel_en === 1'b1) begin
        seen = 1;
        break;
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL sel_wait: no mem_sel_en within 6 cycles, mask=%b", mask);
      return;
    end
    for (int i = 0; i < N; i++) if (bus.req_grant[i]) obs_w = i;
    total++;
    if (bus.req_grant !== oh) begin
      bad++;
      $display("FAIL grant: got %b want %b", bus.req_grant, oh);
    end
    total++;
    if ({bus.mem_addr, bus.mem_wr_data, bus.mem_wr_rd_s} !== {ea, ed, ew}) begin
      bad++;
      $display("FAIL issue_bus: got %h/%h/%b want %h/%h/%b",
               bus.mem_addr, bus.mem_wr_data, bus.mem_wr_rd_s, ea, ed, ew);
    end
    total++;
    if ({bus.rsp_rdata, bus.rsp_ack, bus.rsp_err} !== {prev_rdata, prev_ack, prev_err}) begin
      bad++;
      $display("FAIL rsp_hold: got %h/%h/%b want %h/%h/%b",
               bus.rsp_rdata, bus.rsp_ack, bus.rsp_err, prev_rdata, prev_ack, prev_err);
    end
    scramble_reqs();
    if (drop_mid) bus.req_valid[w] = 1'b0;
    bus.mem_ack = issue_noise ? 4'hF : 4'h0;
    bus.mem_rd_data = $urandom;
    done_at = -1;
    for (int c = 0; c < TO + 4; c++) begin
      @(negedge clk);
      if (bus.req_done !== '0) begin
        done_at = c;
        break;
      end
      total++;
      if (bus.mem_sel_en !== 1'b0 || bus.req_grant !== oh || bus.busy !== 1'b1 ||
          {bus.mem_addr, bus.mem_wr_data, bus.mem_wr_rd_s} !== {ea, ed, ew}) begin
        bad++;
        $display("FAIL wait_hold: cyc %0d sel=%b grant=%b busy=%b bus=%h/%h/%b want 0/%b/1/%h/%h/%b",
                 c, bus.mem_sel_en, bus.req_grant, bus.busy, bus.mem_addr, bus.mem_wr_data,
                 bus.mem_wr_rd_s, oh, ea, ed, ew);
      end
      if (c == delay) begin
        bus.mem_ack = ackv;
        bus.mem_rd_data = rd;
      end else begin
        bus.mem_ack = 4'h0;
        bus.mem_rd_data = $urandom;
      end
    end
    bus.mem_ack = 4'h0;
    total++;
    if (done_at != (exp_err ? TO : delay + 1)) begin
      bad++;
      $display("FAIL done_time: done at wait cycle %0d want %0d", done_at, exp_err ? TO : delay + 1);
    end
    total++;
    if (bus.req_done !== oh || bus.req_grant !== oh) begin
      bad++;
      $display("FAIL done_vec: done=%b grant=%b want %b", bus.req_done, bus.req_grant, oh);
    end
    total++;
    if ({bus.rsp_rdata, bus.rsp_ack, bus.rsp_err} !== {exp_rd, exp_ack, exp_err}) begin
      bad++;
      $display("FAIL rsp: got %h/%h/%b want %h/%h/%b",
               bus.rsp_rdata, bus.rsp_ack, bus.rsp_err, exp_rd, exp_ack, exp_err);
    end
    prev_rdata = exp_rd;
    prev_ack   = exp_ack;
    prev_err   = exp_err;
    @(negedge clk);
    total++;
    if (bus.req_done !== '0 || bus.req_grant !== '0 || bus.busy !== 1'b0 || bus.mem_sel_en !== 1'b0 ||
        {bus.rsp_rdata, bus.rsp_ack, bus.rsp_err} !== {prev_rdata, prev_ack, prev_err}) begin
      bad++;
      $display("FAIL idle_gap: done=%b grant=%b busy=%b sel=%b rsp=%h/%h/%b",
               bus.req_done, bus.req_grant, bus.busy, bus.mem_sel_en,
               bus.rsp_rdata, bus.rsp_ack, bus.rsp_err);
    end
    $display("txn: mask=%b owner=%0d delay=%0d err=%b rdata=%h ack=%h", mask, obs_w, delay,
             bus.rsp_err, bus.rsp_rdata, bus.rsp_ack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_outs: got %h want 0", all_outs());
    end
    rst = 1'b0;
    model_rr = 0;
    @(negedge clk);
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL reset_idle: got %h want 0", all_outs());
    end
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    int w;
    for (int t = 0; t < 5; t++) begin
      run_txn(4'b1111, int'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), $urandom, 0, 0, w);
      total++;
      if (w != order[t]) begin
        bad++;
        $display("FAIL rr_order: txn %0d owner %0d want %0d", t, w, order[t]);
      end
    end
  endtask

  task automatic test_single_write();
    int w;
    bus.req_addr[7:0]  = 8'h10;
    bus.req_wdata[7:0] = 8'hA5;
    bus.req_wr_rd_s[0] = 1'b1;
    run_txn(4'b0001, 1, 4'h1, 32'h1234_5678, 0, 0, w);
    total++;
    if (w != 0 || bus.rsp_ack !== 4'h1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      bad++;
      $display("FAIL single_write: owner=%0d ack=%h err=%b rdata=%h want 0/1/0/0",
               w, bus.rsp_ack, bus.rsp_err, bus.rsp_rdata);
    end
  endtask

  task automatic test_read();
    int w;
    bus.req_addr[23:16] = 8'h03;
    bus.req_wr_rd_s[2]  = 1'b0;
    run_txn(4'b0100, 0, 4'h4, 32'hDEAD_BEEF, 0, 0, w);
    total++;
    if (w != 2 || bus.rsp_rdata !== 32'hDEAD_BEEF || bus.rsp_ack !== 4'h4) begin
      bad++;
      $display("FAIL read: owner=%0d rdata=%h ack=%h want 2/deadbeef/4", w, bus.rsp_rdata, bus.rsp_ack);
    end
  endtask

  task automatic test_timeout();
    int w;
    bus.req_wr_rd_s[1] = 1'b0;
    run_txn(4'b0010, -1, 4'h0, 32'hFFFF_FFFF, 0, 1, w);
    total++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.rsp_ack !== 4'h0) begin
      bad++;
      $display("FAIL timeout: err=%b rdata=%h ack=%h want 1/0/0", bus.rsp_err, bus.rsp_rdata, bus.rsp_ack);
    end
    bus.req_wr_rd_s[3] = 1'b0;
    run_txn(4'b1000, 2, 4'h8, 32'h0BAD_F00D, 0, 0, w);
    total++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0BAD_F00D) begin
      bad++;
      $display("FAIL after_timeout: err=%b rdata=%h want 0/0badf00d", bus.rsp_err, bus.rsp_rdata);
    end
  endtask

  task automatic test_ack_last();
    int w;
    run_txn(4'b0001, TO - 1, 4'h2, 32'hCAFE_0001, 0, 0, w);
    total++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_ack !== 4'h2) begin
      bad++;
      $display("FAIL ack_last: err=%b ack=%h want 0/2", bus.rsp_err, bus.rsp_ack);
    end
  endtask

  task automatic test_random();
    int w, d;
    logic [N-1:0] m;
    for (int t = 0; t < 40; t++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      run_txn(m, d, 4'($urandom_range(1, 15)), $urandom, 1'($urandom), 1'($urandom), w);
    end
  endtask

  task automatic test_async_reset();
    int w;
    bit seen;
    bus.req_valid = 4'b0100;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.mem_sel_en === 1'b1) begin
        seen = 1;
        break;
      end
    end
    @(negedge clk);
    total++;
    if (!seen || bus.busy !== 1'b1) begin
      bad++;
      $display("FAIL arst_setup: sel seen=%0d busy=%b want 1/1", seen, bus.busy);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (all_outs() !== '0) begin
      bad++;
      $display("FAIL arst_outs: got %h want 0", all_outs());
    end
    bus.req_valid = '0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.req_done !== '0 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL arst_hold: done=%b busy=%b want 0/0", bus.req_done, bus.busy);
    end
    rst = 1'b0;
    model_rr = 0;
    prev_rdata = '0;
    prev_ack   = '0;
    prev_err   = 1'b0;
    run_txn(4'b1010, 1, 4'h1, $urandom, 0, 0, w);
    total++;
    if (w != 1) begin
      bad++;
      $display("FAIL arst_rr: owner %0d want 1", w);
    end
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
    bus.req_wr_rd_s = '0;
    bus.mem_rd_data = '0;
    bus.mem_ack     = '0;
    scramble_reqs();
    test_reset();
    test_round_robin();
    test_single_write();
    test_read();
    test_timeout();
    test_ack_last();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
